// File: rtl/ex_muldiv_unit_pkg.sv
// Shared opcodes, FSM states and opcode helpers for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_OP_MUL   = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_OP_MULH  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_OP_MULHU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_OP_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_OP_MOD   = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_OP_MODU  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic op_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU) || (op == MD_OP_MOD) || (op == MD_OP_MODU);
  endfunction

  // MUL.W treats its operands as signed too; its low half is identical either way.
  function automatic logic op_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_MOD);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_iter_core.sv
// Radix-2 restoring divider over unsigned magnitudes, one quotient bit per step.
module ex_muldiv_unit_div_iter_core #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] diff;

  // The partial remainder is always below the divisor, so the trial value fits in DATA_W+1 bits.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    fits    = (shifted >= {1'b0, dvs_q});
    diff    = shifted[DATA_W-1:0] - dvs_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      quo_q <= {quo_q[DATA_W-2:0], fits};
      rem_q <= fits ? diff : shifted[DATA_W-1:0];
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign count_o     = cnt_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit beside the EX stage; holds the pipeline until the result is ready.
// Define MULDIV_DIV_EARLY_OUT_EN to let divides by zero or by a larger divisor skip the iteration loop.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic [MD_OP_W-1:0] op_i,
  input  logic [DATA_W-1:0]  opa_i,
  input  logic [DATA_W-1:0]  opb_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic               cancel_i,
  output logic [DATA_W-1:0]  result_o,
  output logic [ADDR_W-1:0]  waddr_o,
  output logic               result_valid_o,
  output logic               stallreq_o
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int MCNT_W = $clog2(MUL_LAT + 1);

  md_state_e           state_q, state_d;
  logic [MD_OP_W-1:0]  op_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [MCNT_W-1:0]   mul_cnt_q;

  logic                accept, in_signed, in_is_div;
  logic [DATA_W-1:0]   mag_a_in, mag_b_in;
  logic                div_load, div_step;
  logic [DATA_W-1:0]   div_quo, div_rem;
  logic [CNT_W-1:0]    div_cnt;

  logic                q_signed, sign_a, neg_quo;
  logic [2*DATA_W-1:0] mul_a_ext, mul_b_ext, product;
  logic [DATA_W-1:0]   quo_mag, rem_mag, result;

`ifdef MULDIV_DIV_EARLY_OUT_EN
  logic                early_in, early_q;
`endif

  always_comb begin
    in_signed = op_is_signed(op_i);
    in_is_div = op_is_div(op_i);
    accept    = (state_q == ST_IDLE) && req_i && !cancel_i;
    mag_a_in  = (in_signed && opa_i[DATA_W-1]) ? -opa_i : opa_i;
    mag_b_in  = (in_signed && opb_i[DATA_W-1]) ? -opb_i : opb_i;
  end

`ifdef MULDIV_DIV_EARLY_OUT_EN
  assign early_in = (opb_i == '0) || (mag_a_in < mag_b_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      early_q <= 1'b0;
    end else if (accept) begin
      early_q <= in_is_div && early_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      waddr_q   <= '0;
      mul_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_i;
        opa_q     <= opa_i;
        opb_q     <= opb_i;
        waddr_q   <= waddr_i;
        mul_cnt_q <= '0;
      end else if (state_q == ST_MUL) begin
        mul_cnt_q <= mul_cnt_q + MCNT_W'(1);
      end
    end
  end

  // The accept cycle counts toward the multiply latency, so MUL only waits MUL_LAT-1 cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_is_div) begin
`ifdef MULDIV_DIV_EARLY_OUT_EN
            state_d = early_in ? ST_DONE : ST_DIV;
`else
            state_d = ST_DIV;
`endif
          end else begin
            state_d = (MUL_LAT == 1) ? ST_DONE : ST_MUL;
          end
        end
      end
      ST_MUL:  if (mul_cnt_q == MCNT_W'(MUL_LAT - 2)) state_d = ST_DONE;
      ST_DIV:  if (div_cnt == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (cancel_i) state_d = ST_IDLE;
  end

  assign div_load = accept && in_is_div;
  assign div_step = (state_q == ST_DIV);

  ex_muldiv_unit_div_iter_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_div_iter_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (mag_a_in),
    .divisor_i   (mag_b_in),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .count_o     (div_cnt)
  );

  // Operands are sign/zero-extended to the full product width, so a plain modular multiply gives both halves.
  always_comb begin
    q_signed  = op_is_signed(op_q);
    sign_a    = q_signed && opa_q[DATA_W-1];
    neg_quo   = q_signed && (opa_q[DATA_W-1] ^ opb_q[DATA_W-1]);
    mul_a_ext = {{DATA_W{sign_a}}, opa_q};
    mul_b_ext = {{DATA_W{q_signed && opb_q[DATA_W-1]}}, opb_q};
    product   = mul_a_ext * mul_b_ext;
    quo_mag   = div_quo;
    rem_mag   = div_rem;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    if (early_q) begin
      quo_mag = '0;
      rem_mag = sign_a ? -opa_q : opa_q;
    end
`endif
    case (op_q)
      MD_OP_MUL:               result = product[DATA_W-1:0];
      MD_OP_MULH, MD_OP_MULHU: result = product[2*DATA_W-1:DATA_W];
      MD_OP_DIV, MD_OP_DIVU:   result = (opb_q == '0) ? '1 : (neg_quo ? -quo_mag : quo_mag);
      MD_OP_MOD, MD_OP_MODU:   result = sign_a ? -rem_mag : rem_mag;
      default:                 result = product[DATA_W-1:0];
    endcase
  end

  assign result_valid_o = (state_q == ST_DONE);
  assign result_o       = result_valid_o ? result : '0;
  assign waddr_o        = waddr_q;
  assign stallreq_o     = rst && (accept || (state_q == ST_MUL) || (state_q == ST_DIV));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table through a result scoreboard plus
// hand-written cancel/reset sequences. Latency expectations follow MULDIV_DIV_EARLY_OUT_EN.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int DATA_W  = 32;
  localparam int MUL_LAT = 2;
  localparam int ADDR_W  = 5;

  logic               clk;
  logic               rst;
  logic               req_i;
  logic [MD_OP_W-1:0] op_i;
  logic [DATA_W-1:0]  opa_i;
  logic [DATA_W-1:0]  opb_i;
  logic [ADDR_W-1:0]  waddr_i;
  logic               cancel_i;
  logic [DATA_W-1:0]  result_o;
  logic [ADDR_W-1:0]  waddr_o;
  logic               result_valid_o;
  logic               stallreq_o;

  ex_muldiv_unit #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .op_i           (op_i),
    .opa_i          (opa_i),
    .opb_i          (opb_i),
    .waddr_i        (waddr_i),
    .cancel_i       (cancel_i),
    .result_o       (result_o),
    .waddr_o        (waddr_o),
    .result_valid_o (result_valid_o),
    .stallreq_o     (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MD_OP_W-1:0] op;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  exp_res;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] waddr;
    int                lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  function automatic int exp_lat(input logic [MD_OP_W-1:0] op, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b);
`ifdef MULDIV_DIV_EARLY_OUT_EN
    logic              sgn;
    logic [DATA_W-1:0] ma, mb;
`endif
    if (op == MD_OP_MUL || op == MD_OP_MULH || op == MD_OP_MULHU) return MUL_LAT;
`ifdef MULDIV_DIV_EARLY_OUT_EN
    sgn = (op == MD_OP_DIV) || (op == MD_OP_MOD);
    ma  = (sgn && a[DATA_W-1]) ? -a : a;
    mb  = (sgn && b[DATA_W-1]) ? -b : b;
    if (b == '0 || ma < mb) return 1;
`else
    if (a === b && a !== a) return 0;
`endif
    return DATA_W + 1;
  endfunction

  // Called at a negedge in IDLE; returns just after the accepting posedge with req_i dropped.
  task automatic applyStimulus(input logic [MD_OP_W-1:0] op, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b, input logic [ADDR_W-1:0] waddr,
                               input logic [DATA_W-1:0] exp_res, input bit expect_result);
    req_i   = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    waddr_i = waddr;
    #1;
    checkOutput("stall_at_accept", 64'(stallreq_o), 64'(1));
    if (expect_result) sb_q.push_back('{exp_res, waddr, exp_lat(op, a, b)});
    @(posedge clk);
    #1 req_i = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int   lat;
    int   stall_cycles;
    bit   seen;
    exp_t e;
    lat = 0;
    stall_cycles = 1;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (result_valid_o) seen = 1'b1;
      else if (stallreq_o) stall_cycles++;
    end
    if (!seen) begin
      checkOutput({tag, "_timeout"}, 64'(0), 64'(1));
      sb_q.delete();
      return;
    end
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_unexpected_valid"}, 64'(1), 64'(0));
      return;
    end
    e = sb_q.pop_front();
    checkOutput({tag, "_result"}, 64'(result_o), 64'(e.result));
    checkOutput({tag, "_waddr"}, 64'(waddr_o), 64'(e.waddr));
    checkOutput({tag, "_latency"}, 64'(lat), 64'(e.lat));
    checkOutput({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(e.lat));
    checkOutput({tag, "_stall_in_done"}, 64'(stallreq_o), 64'(0));
    @(negedge clk);
    checkOutput({tag, "_valid_one_cycle"}, 64'(result_valid_o), 64'(0));
  endtask

  task automatic runVector(input vec_t v, input logic [ADDR_W-1:0] waddr, input string tag);
    applyStimulus(v.op, v.a, v.b, waddr, v.exp_res, 1'b1);
    waitResult(tag);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int valid_seen;

    vecs.push_back('{MD_OP_MUL,   32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD});
    vecs.push_back('{MD_OP_MULH,  32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFF});
    vecs.push_back('{MD_OP_MULHU, 32'hFFFF_FFFF, 32'd3,         32'h0000_0002});
    vecs.push_back('{MD_OP_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{MD_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{MD_OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{MD_OP_MOD,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{MD_OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD});
    vecs.push_back('{MD_OP_MOD,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{MD_OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{MD_OP_MODU,  32'd5,         32'd0,         32'd5});
    vecs.push_back('{MD_OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{MD_OP_MOD,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB});
    vecs.push_back('{MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{MD_OP_MOD,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{MD_OP_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{MD_OP_MODU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{MD_OP_MOD,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFD});
    vecs.push_back('{MD_OP_DIVU,  32'd3,         32'd10,        32'd0});
    vecs.push_back('{MD_OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF});

    rst      = 1'b0;
    req_i    = 1'b1;
    cancel_i = 1'b0;
    op_i     = MD_OP_DIV;
    opa_i    = 32'd100;
    opb_i    = 32'd7;
    waddr_i  = 5'd3;

    // Reset must hold everything quiet even with a request pending.
    repeat (3) @(negedge clk);
    checkOutput("reset_stall", 64'(stallreq_o), 64'(0));
    checkOutput("reset_valid", 64'(result_valid_o), 64'(0));
    checkOutput("reset_result", 64'(result_o), 64'(0));
    checkOutput("reset_waddr", 64'(waddr_o), 64'(0));
    req_i = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_valid", 64'(result_valid_o), 64'(0));
    checkOutput("post_reset_stall", 64'(stallreq_o), 64'(0));

    foreach (vecs[i]) begin
      runVector(vecs[i], ADDR_W'(i + 1), $sformatf("vec%0d", i));
    end

    // Cancel during the tenth divide iteration, then a multiply issued straight after.
    applyStimulus(MD_OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("cancel_stall_before", 64'(stallreq_o), 64'(1));
    cancel_i = 1'b1;
    @(posedge clk);
    #1 cancel_i = 1'b0;
    @(negedge clk);
    checkOutput("cancel_stall_after", 64'(stallreq_o), 64'(0));
    checkOutput("cancel_valid_after", 64'(result_valid_o), 64'(0));
    runVector('{MD_OP_MUL, 32'd6, 32'd7, 32'd42}, 5'd21, "after_cancel_mul");
    valid_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid_o) valid_seen++;
    end
    checkOutput("cancelled_div_silent", 64'(valid_seen), 64'(0));

    // Request and cancel together: the request is dropped.
    req_i    = 1'b1;
    cancel_i = 1'b1;
    op_i     = MD_OP_MUL;
    opa_i    = 32'd2;
    opb_i    = 32'd2;
    #1;
    checkOutput("req_cancel_stall", 64'(stallreq_o), 64'(0));
    @(posedge clk);
    #1;
    req_i    = 1'b0;
    cancel_i = 1'b0;
    valid_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (result_valid_o || stallreq_o) valid_seen++;
    end
    checkOutput("req_cancel_dropped", 64'(valid_seen), 64'(0));

    // Reset asserted mid-divide clears outputs immediately.
    applyStimulus(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFD, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("mid_div_stall", 64'(stallreq_o), 64'(1));
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_reset_stall", 64'(stallreq_o), 64'(0));
    checkOutput("mid_reset_valid", 64'(result_valid_o), 64'(0));
    checkOutput("mid_reset_result", 64'(result_o), 64'(0));
    checkOutput("mid_reset_waddr", 64'(waddr_o), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    runVector('{MD_OP_DIVU, 32'd100, 32'd7, 32'd14}, 5'd30, "after_reset_divu");
    runVector('{MD_OP_MODU, 32'd100, 32'd7, 32'd2}, 5'd31, "after_reset_modu");

    checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
